// File: rtl/ahb_manager_arbiter_pkg.sv
// Shared types for the AHB manager channel arbiter: hsize, arbiter FSM state and tag width helper.
package ahb_manager_arbiter_pkg;

  typedef logic [2:0] t_hsize;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_OWN
  } t_arb_state;

  // A single channel still needs a 1-bit tag.
  function automatic int unsigned tag_wdt(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/ahb_manager_arbiter_if.sv
// Channel-side and downstream-side signal bundle of the AHB manager arbiter.
interface ahb_manager_arbiter_if
  import ahb_manager_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WDT = 32,
  parameter int unsigned NCH      = 4
);
  logic [NCH-1:0]                o_stall;
  logic [NCH-1:0]                i_idle;
  logic [NCH-1:0][DATA_WDT-1:0]  i_wr_data;
  logic [NCH-1:0][31:0]          i_addr;
  logic [NCH-1:0][31:0]          i_mask;
  t_hsize [NCH-1:0]              i_size;
  logic [NCH-1:0]                i_wr;
  logic [NCH-1:0]                i_rd;
  logic [NCH-1:0]                i_first_xfer;
  logic [NCH-1:0][15:0]          i_min_len;
  logic [DATA_WDT-1:0]           o_data;
  logic [31:0]                   o_addr;
  logic [NCH-1:0]                o_dav;

  logic                          o_dn_idle;
  logic [DATA_WDT-1:0]           o_dn_wr_data;
  logic [31:0]                   o_dn_addr;
  logic [31:0]                   o_dn_mask;
  t_hsize                        o_dn_size;
  logic                          o_dn_wr;
  logic                          o_dn_rd;
  logic [15:0]                   o_dn_min_len;
  logic                          o_dn_first_xfer;
  logic                          i_dn_stall;
  logic [DATA_WDT-1:0]           i_dn_data;
  logic [31:0]                   i_dn_addr;
  logic                          i_dn_dav;
  logic                          o_err;

  modport slave (
    input  i_idle, i_wr_data, i_addr, i_mask, i_size, i_wr, i_rd, i_first_xfer, i_min_len,
    input  i_dn_stall, i_dn_data, i_dn_addr, i_dn_dav,
    output o_stall, o_data, o_addr, o_dav, o_err,
    output o_dn_idle, o_dn_wr_data, o_dn_addr, o_dn_mask, o_dn_size, o_dn_wr, o_dn_rd,
    output o_dn_min_len, o_dn_first_xfer
  );

  modport master (
    output i_idle, i_wr_data, i_addr, i_mask, i_size, i_wr, i_rd, i_first_xfer, i_min_len,
    output i_dn_stall, i_dn_data, i_dn_addr, i_dn_dav,
    input  o_stall, o_data, o_addr, o_dav, o_err,
    input  o_dn_idle, o_dn_wr_data, o_dn_addr, o_dn_mask, o_dn_size, o_dn_wr, o_dn_rd,
    input  o_dn_min_len, o_dn_first_xfer
  );

endinterface

// File: rtl/ahb_manager_tag_fifo.sv
// Synchronous FIFO of channel tags for outstanding read beats; push and pop may coincide,
// including when full.
module ahb_manager_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_manager_arbiter.sv
// Round-robin merge of NCH command channels onto one AHB manager user port, granting per burst
// sequence and routing in-order read data back through a tag FIFO.
module ahb_manager_arbiter
  import ahb_manager_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WDT  = 32,
  parameter int unsigned NCH       = 4,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  ahb_manager_arbiter_if.slave bus
);
  localparam int unsigned TW = tag_wdt(NCH);

  t_arb_state          state_q, state_d;
  logic [TW-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]      req;
  logic                gnt_found;
  logic [TW-1:0]       gnt_idx, cand;
  logic                tag_full, tag_empty, tag_push, tag_pop, tag_block, accept;
  logic [TW-1:0]       tag_head;
  logic                err_q;
  logic [NCH-1:0]      dav_q, dav_d;
  logic [DATA_WDT-1:0] data_q;
  logic [31:0]         addr_q;

  assign req = ~bus.i_idle & bus.i_first_xfer & (bus.i_rd | bus.i_wr);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = TW'((32'(rr_ptr_q) + i) % NCH);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    rr_ptr_d             = rr_ptr_q;
    tag_block            = 1'b0;
    accept               = 1'b0;
    tag_push             = 1'b0;
    bus.o_stall          = '1;
    bus.o_dn_idle        = 1'b1;
    bus.o_dn_wr          = 1'b0;
    bus.o_dn_rd          = 1'b0;
    bus.o_dn_first_xfer  = 1'b0;
    bus.o_dn_wr_data     = '0;
    bus.o_dn_addr        = '0;
    bus.o_dn_mask        = '0;
    bus.o_dn_size        = '0;
    bus.o_dn_min_len     = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_found) begin
          owner_d  = gnt_idx;
          rr_ptr_d = TW'((32'(gnt_idx) + 1) % NCH);
          state_d  = ARB_OWN;
        end
      end
      ARB_OWN: begin
        // A read beat that cannot get a tag is held on the channel, not dropped.
        tag_block            = bus.i_rd[owner_q] & ~bus.i_idle[owner_q] & tag_full;
        accept               = ~(bus.i_dn_stall | tag_block);
        bus.o_stall[owner_q] = ~accept;
        bus.o_dn_wr_data     = bus.i_wr_data[owner_q];
        bus.o_dn_addr        = bus.i_addr[owner_q];
        bus.o_dn_mask        = bus.i_mask[owner_q];
        bus.o_dn_size        = bus.i_size[owner_q];
        bus.o_dn_min_len     = bus.i_min_len[owner_q];
        bus.o_dn_idle        = tag_block ? 1'b0 : bus.i_idle[owner_q];
        bus.o_dn_wr          = tag_block ? 1'b0 : bus.i_wr[owner_q];
        bus.o_dn_rd          = tag_block ? 1'b0 : bus.i_rd[owner_q];
        bus.o_dn_first_xfer  = tag_block ? 1'b0 : bus.i_first_xfer[owner_q];
        tag_push             = accept & bus.o_dn_rd;
        if (accept && bus.i_idle[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign tag_pop = bus.i_dn_dav & ~tag_empty;

  ahb_manager_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (i_hclk),
    .rst       (i_hreset),
    .push      (tag_push),
    .push_data (owner_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    dav_d = '0;
    if (tag_pop) dav_d[tag_head] = 1'b1;
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      dav_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      // Response with nothing outstanding is a downstream protocol violation.
      err_q    <= err_q | (bus.i_dn_dav & tag_empty);
      dav_q    <= dav_d;
      data_q   <= bus.i_dn_data;
      addr_q   <= bus.i_dn_addr;
    end
  end

  assign bus.o_err  = err_q;
  assign bus.o_dav  = dav_q;
  assign bus.o_data = data_q;
  assign bus.o_addr = addr_q;

endmodule
